usb_rx_phy: RTL
===============

// Module: usb_rx_phy
// PURPOSE
//  Parametrised USB 1.1 receive PHY; replaces the raw per-clock D+ byte sampler.
//  - Oversamples D+/D-, recovers bit timing (DPLL), NRZI-decodes, strips stuffed bits.
//  - Detects SYNC and EOP; delivers LSB-first bytes with a valid strobe to the packet layer.
//  - Sits between the Pmod pad tristate logic and the USB packet decoder.
// PARAMETERS
//  OVERSAMPLE   4  clk_i cycles per USB bit (48 MHz / 12 Mbps FS); must be >= 4 and even
//  SYNC_STAGES  2  metastability flops on dp_i/dn_i; must be >= 2
//  LOW_SPEED    0  0: J = (dp=1, dn=0) full-speed; 1: J = (dp=0, dn=1) low-speed
// PORTS
//  clk_i     in   1  system clock
//  rst_i     in   1  asynchronous reset, active-low
//  dp_i      in   1  D+ pad input (asynchronous)
//  dn_i      in   1  D- pad input (asynchronous)
//  rx_en_i   in   1  receive enable; low while this end transmits
//  data_o    out  8  received byte, LSB = first bit on the wire; valid only with valid_o
//  valid_o   out  1  one-cycle strobe per complete byte
//  active_o  out  1  high from SYNC detect until EOP, error or disable
//  eop_o     out  1  one-cycle strobe on EOP (SE0 followed by J)
//  err_o     out  1  one-cycle strobe: stuff error, SE1, or bad partial byte at EOP
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; prev line state = J; phase counter = 0.
//  - Sync: SYNC_STAGES flops per line. Line state decodes to J, K, SE0 or SE1.
//  - DPLL:
//    - phase counter, width $clog2(OVERSAMPLE), cleared on any synced line-state change;
//      otherwise increments and wraps OVERSAMPLE-1 -> 0.
//    - sample strobe when counter == OVERSAMPLE/2.
//  - NRZI: on each strobe with J/K, bit = 1 if equal to previous sampled J/K, else 0.
//  - States: IDLE -> SYNC -> DATA -> (IDLE | ERR_WAIT).
//    - IDLE: wait for first sampled K -> SYNC.
//    - SYNC: shift decoded bits (first bit is K).
//      - Shift reg == 8'h80 (KJKJKJKK) -> DATA; active_o=1 from the next cycle.
//      - Any SE0/SE1, or 8 bits without match -> IDLE silently.
//    - DATA:
//      - Ones counter: after six consecutive 1s, next bit is dropped if 0.
//      - If that bit is 1 -> err_o, -> ERR_WAIT.
//      - 8th kept bit -> data_o updated, valid_o=1 for 1 cycle, 1 cycle after the strobe.
//      - Sampled SE0 -> await next strobe. J -> eop_o=1, active_o=0 -> IDLE.
//        K or SE1 -> err_o -> ERR_WAIT.
//      - Partial byte at EOP: 0 or 1 bits (dribble) discarded cleanly.
//        2..7 bits -> err_o in the same cycle as eop_o; partial byte never on valid_o.
//      - Sampled SE1 -> err_o -> ERR_WAIT.
//    - ERR_WAIT: active_o=0; wait for sampled SE0 then J, or 8 consecutive sampled J -> IDLE.
//  - rx_en_i low (synchronous): next cycle state = IDLE, active_o=0.
//    No eop_o/err_o/valid_o while low; prev line state preset to J.
//  - Reset mid-packet: outputs 0 immediately (async); no strobe on release.
//  - Simultaneous valid_o and eop_o never occur; valid_o and err_o may not coincide.
//  - Latency: pad edge -> strobe <= SYNC_STAGES + OVERSAMPLE/2 + 1 cycles.
// STRUCTURE
//  - Package usb_phy_pkg:
//    - line-state enum LS_J/LS_K/LS_SE0/LS_SE1
//    - rx state enum RX_IDLE/RX_SYNC/RX_DATA/RX_ERR_WAIT
//    - constants SYNC_PATTERN = 8'h80, STUFF_LIMIT = 6, IDLE_J_BITS = 8
//  - Sub-module usb_rx_dpll: synchroniser, line-state decode, phase counter.
//    Outputs the sampled line state and sample strobe.
//  - Top holds the NRZI, destuff, shifter and FSM.
// TESTING  (OVERSAMPLE=4 unless stated)
//  - Reset: drive rst_i low mid-byte -> all outputs 0 same cycle; no valid_o after release until a new SYNC.
//  - Packet SYNC,0xA5,0x3C,SE0x2,J -> valid_o twice with data_o 0xA5 then 0x3C.
//    Then eop_o once, err_o never, active_o high only between SYNC and EOP.
//  - Byte 0xFF with stuffed 0 after six 1s -> data_o 0xFF, exactly one valid_o, no err_o.
//  - Seven 1s with no stuffed 0 -> err_o one cycle, active_o 0.
//    Following bytes ignored until idle + new SYNC.
//  - Bit periods alternating 3/5 clocks over SYNC,0x5A,EOP -> 0x5A received, no err_o.
//  - EOP after 3 data bits -> eop_o and err_o same cycle, no valid_o.
//  - rx_en_i low mid-packet -> active_o 0 next cycle, no eop_o.

Source files
------------

// File: rtl/usb_phy_pkg.sv
// Shared types and constants for the USB 1.1 receive PHY.
//  line_state_t : decoded bus state (J, K, SE0, SE1)
//  rx_state_t   : receive FSM state
//  SYNC_PATTERN : LSB-first decoded value of the SYNC field (KJKJKJKK)
//  STUFF_LIMIT  : consecutive ones after which a stuffed zero follows
//  IDLE_J_BITS  : consecutive J bits that end error recovery
package usb_phy_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_SYNC     = 2'd1,
    RX_DATA     = 2'd2,
    RX_ERR_WAIT = 2'd3
  } rx_state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [2:0]  STUFF_LIMIT  = 3'd6;
  localparam int unsigned IDLE_J_BITS  = 8;

endpackage

// File: rtl/usb_rx_dpll.sv
// Pad synchroniser, line-state decoder and bit-timing recovery.
//  clk_i    in  system clock
//  rst_i    in  asynchronous reset, active-low
//  dp_i     in  D+ pad (asynchronous)
//  dn_i     in  D- pad (asynchronous)
//  ls_o     out synchronised line state (valid when strobe_o is high)
//  strobe_o out one-cycle strobe at the centre of each recovered bit
module usb_rx_dpll
  import usb_phy_pkg::*;
#(
  parameter int OVERSAMPLE  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOW_SPEED   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dp_i,
  input  logic        dn_i,
  output line_state_t ls_o,
  output logic        strobe_o
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PHASE_MAX  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  // Idle (J) pad levels, so the synchroniser leaves reset without a fake edge
  localparam logic IDLE_DP = (LOW_SPEED == 0);
  localparam logic IDLE_DN = (LOW_SPEED != 0);

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dn_sync;
  line_state_t            r_ls_prev;
  logic [PW-1:0]          r_phase;
  line_state_t            w_ls;
  logic                   w_change;
  logic [PW-1:0]          w_phase;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dp_sync <= {SYNC_STAGES{IDLE_DP}};
      r_dn_sync <= {SYNC_STAGES{IDLE_DN}};
      r_ls_prev <= LS_J;
      r_phase   <= '0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], dp_i};
      r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], dn_i};
      r_ls_prev <= w_ls;
      r_phase   <= w_phase;
    end
  end

  always_comb begin
    w_ls = LS_SE0;
    case ({r_dp_sync[SYNC_STAGES-1], r_dn_sync[SYNC_STAGES-1]})
      2'b00:   w_ls = LS_SE0;
      2'b11:   w_ls = LS_SE1;
      2'b10:   w_ls = (LOW_SPEED != 0) ? LS_K : LS_J;
      default: w_ls = (LOW_SPEED != 0) ? LS_J : LS_K;
    endcase
  end

  // Phase is 0 in the cycle a new line state first appears, so the strobe
  // lands OVERSAMPLE/2 cycles into the bit even for a short (3-clock) bit.
  assign w_change = (w_ls != r_ls_prev);
  assign w_phase  = w_change ? '0 :
                    (r_phase == PHASE_MAX) ? '0 : (r_phase + PHASE_ONE);

  assign ls_o     = w_ls;
  assign strobe_o = (w_phase == PHASE_HALF);

endmodule

// File: rtl/usb_rx_phy.sv
// USB 1.1 receive PHY: NRZI decode, bit de-stuffing, SYNC/EOP detection and
// byte assembly on top of the oversampling DPLL.
//  clk_i    in  system clock
//  rst_i    in  asynchronous reset, active-low
//  dp_i     in  D+ pad (asynchronous)
//  dn_i     in  D- pad (asynchronous)
//  rx_en_i  in  receive enable; low while this end transmits
//  data_o   out received byte, LSB first on the wire (valid with valid_o)
//  valid_o  out one-cycle strobe per complete byte
//  active_o out high from SYNC detect until EOP, error or disable
//  eop_o    out one-cycle strobe on EOP (SE0 followed by J)
//  err_o    out one-cycle strobe: stuff error, SE1, bad EOP, bad partial byte
module usb_rx_phy
  import usb_phy_pkg::*;
#(
  parameter int OVERSAMPLE  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOW_SPEED   = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dp_i,
  input  logic       dn_i,
  input  logic       rx_en_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_o,
  output logic       eop_o,
  output logic       err_o
);

  line_state_t w_ls;
  logic        w_strobe;

  usb_rx_dpll #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES),
    .LOW_SPEED  (LOW_SPEED)
  ) u_dpll (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .dp_i    (dp_i),
    .dn_i    (dn_i),
    .ls_o    (w_ls),
    .strobe_o(w_strobe)
  );

  rx_state_t   r_state;
  line_state_t r_prev_jk;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_ones;
  logic        r_se0_seen;
  logic [2:0]  r_jcnt;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_eop;
  logic        r_err;
  logic        r_active;

  logic        w_is_jk;
  logic        w_bit;
  logic [7:0]  w_shift_next;
  logic        w_data_err;

  assign w_is_jk      = (w_ls == LS_J) || (w_ls == LS_K);
  // NRZI: no transition means 1
  assign w_bit        = (w_ls == r_prev_jk);
  assign w_shift_next = {w_bit, r_shift[7:1]};
  // Abort conditions inside a packet: SE1, K after SE0, or a seventh one
  assign w_data_err   = (w_ls == LS_SE1) ||
                        (r_se0_seen && (w_ls == LS_K)) ||
                        (!r_se0_seen && w_is_jk && (r_ones == STUFF_LIMIT) && w_bit);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RX_IDLE;
      r_prev_jk  <= LS_J;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ones     <= '0;
      r_se0_seen <= 1'b0;
      r_jcnt     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_eop      <= 1'b0;
      r_err      <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
      if (!rx_en_i) begin
        r_state   <= RX_IDLE;
        r_active  <= 1'b0;
        r_prev_jk <= LS_J;
      end else if (w_strobe) begin
        if (w_is_jk) r_prev_jk <= w_ls;
        case (r_state)
          RX_IDLE: begin
            // The first K is also the first SYNC bit
            if (w_ls == LS_K) begin
              r_state   <= RX_SYNC;
              r_shift   <= w_shift_next;
              r_bit_cnt <= 3'd1;
            end
          end
          RX_SYNC: begin
            if (!w_is_jk) begin
              r_state <= RX_IDLE;
            end else begin
              r_shift <= w_shift_next;
              if (r_bit_cnt == 3'd7) begin
                if (w_shift_next == SYNC_PATTERN) begin
                  r_state    <= RX_DATA;
                  r_active   <= 1'b1;
                  r_bit_cnt  <= '0;
                  r_ones     <= '0;
                  r_se0_seen <= 1'b0;
                end else begin
                  r_state <= RX_IDLE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          RX_DATA: begin
            if (w_data_err) begin
              r_err      <= 1'b1;
              r_active   <= 1'b0;
              r_state    <= RX_ERR_WAIT;
              r_se0_seen <= 1'b0;
              r_jcnt     <= '0;
            end else if (w_ls == LS_SE0) begin
              r_se0_seen <= 1'b1;
            end else if (r_se0_seen) begin
              // J after SE0: end of packet; up to one dribble bit is tolerated
              r_eop    <= 1'b1;
              r_active <= 1'b0;
              r_state  <= RX_IDLE;
              if (r_bit_cnt >= 3'd2) r_err <= 1'b1;
            end else if (r_ones == STUFF_LIMIT) begin
              r_ones <= '0;  // stuffed zero, dropped
            end else begin
              r_ones    <= w_bit ? (r_ones + 3'd1) : 3'd0;
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_data  <= w_shift_next;
                r_valid <= 1'b1;
              end
            end
          end
          RX_ERR_WAIT: begin
            if (w_ls == LS_SE0) begin
              r_se0_seen <= 1'b1;
              r_jcnt     <= '0;
            end else if (w_ls == LS_J) begin
              if (r_se0_seen || (r_jcnt == 3'(IDLE_J_BITS - 1))) begin
                r_state <= RX_IDLE;
              end else begin
                r_jcnt <= r_jcnt + 3'd1;
              end
            end else begin
              r_se0_seen <= 1'b0;
              r_jcnt     <= '0;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Strobes are masked while disabled so none leak out in the disabling cycle
  assign data_o   = r_data;
  assign valid_o  = r_valid & rx_en_i;
  assign eop_o    = r_eop & rx_en_i;
  assign err_o    = r_err & rx_en_i;
  assign active_o = r_active;

endmodule
